// File: rtl/dcm_prog_ctrl.sv
// Slow-clock divider programming controller: arbitrates two requesters and walks the divider
// through ISSUE/WAIT/RESP. Optional WAIT timeout enabled by defining DCM_CTRL_TIMEOUT_EN.
module dcm_prog_ctrl #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [2:0] sel_a,
  input  logic [2:0] sel_b,
  input  logic [2:0] prog_out,
  output logic [2:0] prog_in,
  output logic       update,
  output logic [1:0] grant,
  output logic       done,
  output logic       err,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state_q, state_d;
  logic [2:0] target_q, target_d;
  logic       gsel_q, gsel_d;   // 0 = A, 1 = B
  logic       ptr_q, ptr_d;     // 1 = B has priority on a tie
  logic       pick;
  logic [2:0] pick_sel;
  logic       timed_out;

  logic [2:0] prog_in_q;
  logic       update_q, done_q, busy_q;
  logic [1:0] grant_q;

`ifdef DCM_CTRL_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
  logic             err_q;
  assign timed_out = to_q;
  assign err       = err_q;
`else
  assign timed_out = 1'b0;
  assign err       = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    gsel_d   = gsel_q;
    ptr_d    = ptr_q;
`ifdef DCM_CTRL_TIMEOUT_EN
    cnt_d    = cnt_q;
    to_d     = to_q;
`endif
    pick     = (req == 2'b11) ? ptr_q : req[1];
    pick_sel = pick ? sel_b : sel_a;
    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          gsel_d   = pick;
          ptr_d    = ~pick;
          target_d = pick_sel;
`ifdef DCM_CTRL_TIMEOUT_EN
          to_d     = 1'b0;
`endif
          // Divider already at the requested setting: skip the update handshake.
          state_d  = (pick_sel == prog_out) ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef DCM_CTRL_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (prog_out == target_q) begin
          state_d = RESP;
`ifdef DCM_CTRL_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = RESP;
          to_d    = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
`endif
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; outputs follow the state one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gsel_q    <= 1'b0;
      ptr_q     <= 1'b0;
      prog_in_q <= 3'd0;
      update_q  <= 1'b0;
      grant_q   <= 2'b00;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gsel_q    <= gsel_d;
      ptr_q     <= ptr_d;
      prog_in_q <= (state_q == ISSUE) ? target_q : prog_in_q;
      update_q  <= (state_q == ISSUE);
      grant_q   <= (state_q == IDLE) ? 2'b00 : (gsel_q ? 2'b10 : 2'b01);
      done_q    <= (state_q == RESP) && !timed_out;
      busy_q    <= (state_q != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    target_q <= target_d;
  end

`ifdef DCM_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
      err_q <= (state_q == RESP) && to_q;
    end
  end
`endif

  assign prog_in = prog_in_q;
  assign update  = update_q;
  assign grant   = grant_q;
  assign done    = done_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_dcm_prog_ctrl.sv
// Bench for dcm_prog_ctrl: vector table plus hand sequences, responses checked against a queue.
module tb_dcm_prog_ctrl;
  localparam int TO = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [2:0] sel_a, sel_b, prog_out, prog_in;
  logic       update, done, err, busy;
  logic [1:0] grant;

  always #5 clk = ~clk;

  dcm_prog_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .sel_a(sel_a), .sel_b(sel_b),
    .prog_out(prog_out), .prog_in(prog_in), .update(update),
    .grant(grant), .done(done), .err(err), .busy(busy)
  );

  typedef struct {
    logic [1:0] req;
    logic [2:0] sa, sb, po;
    logic       skip;
    logic [1:0] g;
    logic [2:0] pi;
  } vec_t;

  typedef struct {
    logic [1:0] g;
    logic [2:0] pi;
    int         upd;
    logic       e;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[6];

  int errors = 0, checks = 0;
  int div_delay = 4;
  bit div_en = 1'b1;
  bit pend = 1'b0;
  int pcnt = 0;
  logic [2:0] pval = 3'd0;
  int upd_cnt = 0, gcyc = 0, ndone = 0, cyc = 0;
  int last_done_cyc = 0, last_upd_cyc = 0, start_cyc = 0, nd_before = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample outputs 1 time unit after the edge, run divider model and scoreboard.
  task automatic tick;
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (update) begin
      upd_cnt++;
      last_upd_cyc = cyc;
      if (div_en) begin
        pend = 1'b1;
        pcnt = div_delay;
        pval = prog_in;
      end
    end else if (pend) begin
      pcnt--;
      if (pcnt <= 0) begin
        prog_out = pval;
        pend = 1'b0;
      end
    end
    if (grant != 2'b00) gcyc++;
    if (done || err) begin
      ndone++;
      last_done_cyc = cyc;
      chk("done_err_exclusive", int'(done & err), 0);
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: done=%0b err=%0b with nothing outstanding", done, err);
      end else begin
        e = sbq.pop_front();
        chk("resp_grant", grant, e.g);
        chk("resp_prog_in", prog_in, e.pi);
        chk("resp_updates", upd_cnt, e.upd);
        chk("resp_err", err, e.e);
      end
      upd_cnt = 0;
    end
  endtask

  task automatic wait_resp(input int n, input int budget, input string name);
    int t = 0;
    int target = ndone + n;
    while (ndone < target && t < budget) begin
      tick();
      t++;
    end
    chk(name, ndone, target);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_prog_in"}, prog_in, 0);
    chk({tag, "_update"}, update, 0);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req = 2'b00;
    pend = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 2'b00; sel_a = 3'd0; sel_b = 3'd0; prog_out = 3'd0;
    do_reset();

    //             req    sa    sb    po    skip  grant  prog_in
    vecs[0] = '{2'b01, 3'd3, 3'd0, 3'd0, 1'b0, 2'b01, 3'd3};
    vecs[1] = '{2'b10, 3'd0, 3'd5, 3'd5, 1'b1, 2'b10, 3'd3};
    vecs[2] = '{2'b10, 3'd0, 3'd7, 3'd5, 1'b0, 2'b10, 3'd7};
    vecs[3] = '{2'b01, 3'd7, 3'd0, 3'd7, 1'b1, 2'b01, 3'd7};
    vecs[4] = '{2'b11, 3'd0, 3'd6, 3'd2, 1'b0, 2'b10, 3'd6};
    vecs[5] = '{2'b11, 3'd0, 3'd6, 3'd6, 1'b0, 2'b01, 3'd0};

    foreach (vecs[i]) begin
      prog_out = vecs[i].po;
      sel_a = vecs[i].sa;
      sel_b = vecs[i].sb;
      upd_cnt = 0;
      gcyc = 0;
      sbq.push_back('{vecs[i].g, vecs[i].pi, vecs[i].skip ? 0 : 1, 1'b0});
      start_cyc = cyc;
      req = vecs[i].req;
      wait_resp(1, 100, "vec_resp_arrived");
      req = 2'b00;
      if (vecs[i].skip) begin
        chk("skip_latency", last_done_cyc - start_cyc, 2);
        chk("skip_grant_cycles", gcyc, 1);
      end
      tick();
      chk("vec_busy_after", busy, 0);
      chk("vec_grant_after", grant, 0);
    end

    // Both requesters held: service must alternate A, B, A.
    do_reset();
    prog_out = 3'd0; sel_a = 3'd1; sel_b = 3'd2; div_delay = 2;
    sbq.push_back('{2'b01, 3'd1, 1, 1'b0});
    sbq.push_back('{2'b10, 3'd2, 1, 1'b0});
    sbq.push_back('{2'b01, 3'd1, 1, 1'b0});
    upd_cnt = 0;
    req = 2'b11;
    wait_resp(3, 300, "rr_resp_arrived");
    req = 2'b00;
    tick();
    chk("rr_busy_after", busy, 0);

    // Target is latched at grant; sel change and req drop during WAIT are ignored.
    div_delay = 6; prog_out = 3'd0; sel_a = 3'd2;
    upd_cnt = 0;
    sbq.push_back('{2'b01, 3'd2, 1, 1'b0});
    req = 2'b01;
    repeat (4) tick();
    sel_a = 3'd6;
    req = 2'b00;
    wait_resp(1, 60, "latch_resp_arrived");
    tick();
    chk("latch_busy_after", busy, 0);

    // Reset asserted while stuck in WAIT.
    div_en = 1'b0; prog_out = 3'd0; sel_a = 3'd5; upd_cnt = 0;
    req = 2'b01;
`ifdef DCM_CTRL_TIMEOUT_EN
    repeat (5) tick();
`else
    repeat (30) tick();
`endif
    chk("wait_busy", busy, 1);
    chk("wait_grant", grant, 2'b01);
    chk("wait_prog_in", prog_in, 5);
    nd_before = ndone;
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    req = 2'b00;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk("midrst_busy_after", busy, 0);
    chk("midrst_no_resp", ndone, nd_before);

`ifdef DCM_CTRL_TIMEOUT_EN
    // Divider never answers: err after TO WAIT cycles, prog_in keeps target.
    prog_out = 3'd0; sel_a = 3'd4; upd_cnt = 0;
    sbq.push_back('{2'b01, 3'd4, 1, 1'b1});
    req = 2'b01;
    wait_resp(1, 60, "to_resp_arrived");
    chk("to_latency", last_done_cyc - last_upd_cyc, TO + 1);
    req = 2'b00;
    tick();
    chk("to_busy_after", busy, 0);
`endif
    div_en = 1'b1;

    chk("queue_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
